// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_arbiter
//  Purpose  : Round-robin front end that shares one pipelined floating-point
//             multiplier between NREQ requesters. Accepts up to one operation
//             per cycle, tracks ownership with a tag pipeline matching the
//             multiplier depth, and routes each result back to its owner in
//             issue order.
//  Revision : 1.0  initial release
// ============================================================================
module fmul_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 6,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              REQ_VALID,
    input  logic [NREQ*WIDTH-1:0]        REQ_OP1,
    input  logic [NREQ*WIDTH-1:0]        REQ_OP2,
    input  logic [NREQ-1:0]              REQ_EXCE,
    output logic [NREQ-1:0]              REQ_READY,
    input  logic                         HOLD,
    output logic [WIDTH-1:0]             MUL_OP1,
    output logic [WIDTH-1:0]             MUL_OP2,
    output logic                         MUL_EXCE_IN,
    input  logic [WIDTH-1:0]             MUL_RESULT,
    input  logic                         MUL_EXCE_OUT,
    output logic [NREQ-1:0]              RSP_VALID,
    output logic [WIDTH-1:0]             RSP_RESULT,
    output logic                         RSP_EXCE,
    output logic [IDW-1:0]               RSP_ID,
    output logic                         BUSY,
    output logic [$clog2(MUL_LAT+1)-1:0] OUTSTANDING
);

    localparam int c_CNT_W = $clog2(MUL_LAT + 1);

    // Round-robin pointer. r_have_last stays low until the first grant after
    // reset so that the search then begins at requester 0 even though the
    // pointer itself resets to 0.
    logic [IDW-1:0]     r_last;
    logic               r_have_last;

    logic               w_grant;
    logic [IDW-1:0]     w_grant_id;
    logic [NREQ-1:0]    w_ready;
    int                 w_start;
    int                 w_dist;
    int                 w_best;

    // Ownership tags travelling alongside the multiplier pipeline.
    logic [MUL_LAT-1:0] r_tag_v;
    logic [IDW-1:0]     r_tag_id [MUL_LAT];
    logic               w_retire;

    logic [c_CNT_W-1:0] r_outstanding;

    // Pick the valid requester closest (in wrap-around order) to the search start.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = '0;
        w_ready    = '0;
        w_start    = 0;
        w_dist     = 0;
        w_best     = NREQ;
        if (r_have_last) begin
            w_start = int'(r_last) + 1;
        end
        if (!HOLD) begin
            for (int i = 0; i < NREQ; i++) begin
                w_dist = (i + 2 * NREQ - w_start) % NREQ;
                if (REQ_VALID[i] && (w_dist < w_best)) begin
                    w_best     = w_dist;
                    w_grant_id = IDW'(i);
                end
            end
        end
        w_grant = (w_best < NREQ);
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_grant && (w_grant_id == IDW'(i));
        end
    end

    assign REQ_READY = w_ready;

    // Steer the granted requester's slice to the multiplier; zero when idle.
    always_comb begin
        MUL_OP1     = '0;
        MUL_OP2     = '0;
        MUL_EXCE_IN = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ready[i]) begin
                MUL_OP1     = REQ_OP1[i*WIDTH +: WIDTH];
                MUL_OP2     = REQ_OP2[i*WIDTH +: WIDTH];
                MUL_EXCE_IN = REQ_EXCE[i];
            end
        end
    end

    // Remember the most recent grant; a grant always implies a handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last      <= '0;
            r_have_last <= 1'b0;
        end else if (w_grant) begin
            r_last      <= w_grant_id;
            r_have_last <= 1'b1;
        end
    end

    // Tag pipeline advances every cycle, mirroring the multiplier stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tag_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_grant_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_retire = r_tag_v[MUL_LAT-1];

    // In-flight count: up on issue, down on retire, steady when both happen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_retire})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign OUTSTANDING = r_outstanding;
    assign BUSY        = (r_outstanding != '0);

    // Capture the multiplier output when the tail tag is live; otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RSP_VALID  <= '0;
            RSP_RESULT <= '0;
            RSP_EXCE   <= 1'b0;
            RSP_ID     <= '0;
        end else begin
            RSP_VALID <= '0;
            if (w_retire) begin
                RSP_VALID  <= NREQ'(1) << r_tag_id[MUL_LAT-1];
                RSP_RESULT <= MUL_RESULT;
                RSP_EXCE   <= MUL_EXCE_OUT;
                RSP_ID     <= r_tag_id[MUL_LAT-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width, which matches the shared pipelined floating-point multiplier.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter MUL_LAT, default 6: multiplier register stages, counted from the operand-sampling edge to the result edge.
REQ-004 Parameter IDW, default log2(NREQ): requester-ID width.
REQ-005 CLK  in  1: single clock; every flop is rising-edge.
REQ-006 RST  in  1: asynchronous, active-high reset.
REQ-007 REQ_VALID  in  NREQ: bit i = requester i presents an operation.
REQ-008 REQ_OP1, REQ_OP2  in  NREQ*WIDTH: packed operands; slice i = [i*WIDTH +: WIDTH].
REQ-009 REQ_EXCE  in  NREQ: exception-in flag per requester.
REQ-010 REQ_READY  out  NREQ: grant; the handshake occurs when REQ_VALID[i] and REQ_READY[i] are both high at a CLK edge.
REQ-011 HOLD  in  1: when high, no new grants are issued and in-flight operations drain.
REQ-012 MUL_OP1, MUL_OP2  out  WIDTH: operands to the multiplier.
REQ-013 MUL_EXCE_IN  out  1: exception-in to the multiplier.
REQ-014 MUL_RESULT  in  WIDTH: result from the multiplier.
REQ-015 MUL_EXCE_OUT  in  1: exception-out from the multiplier.
REQ-016 RSP_VALID  out  NREQ: one-hot, one-cycle response strobe for the owning requester.
REQ-017 RSP_RESULT  out  WIDTH: registered result.
REQ-018 RSP_EXCE  out  1: registered exception.
REQ-019 RSP_ID  out  IDW: registered owner ID.
REQ-020 BUSY  out  1: high while any operation is in flight.
REQ-021 OUTSTANDING  out  log2(MUL_LAT+1): count of in-flight operations.

Function
REQ-022 Arbitration shall be round-robin; a pointer LAST holds the most recently granted index, and the search starts at LAST+1 and wraps modulo NREQ.
REQ-023 REQ_READY shall be combinational from REQ_VALID, LAST and HOLD, with at most one bit high; no bit shall be high when HOLD=1 or REQ_VALID=0.
REQ-024 LAST shall update to the granted index only on a handshake edge; otherwise it holds.
REQ-025 One operation shall be accepted per cycle at most, with no bubble between back-to-back grants (full throughput).
REQ-026 MUL_OP1/MUL_OP2/MUL_EXCE_IN shall combinationally mux the granted slice; when there is no grant they shall be driven to 0.
REQ-027 A tag pipeline of MUL_LAT entries {valid, id} shall advance every cycle.
- Entry 1 loads {1, granted id} on a handshake edge and {0, x} otherwise.
REQ-028 At edge k+MUL_LAT, for a handshake at edge k, the block shall capture MUL_RESULT/MUL_EXCE_OUT into RSP_RESULT/RSP_EXCE and the id into RSP_ID.
- RSP_VALID[id] is high for exactly the following cycle.
REQ-029 When the tail tag is invalid, RSP_VALID shall be 0 and RSP_RESULT/RSP_EXCE/RSP_ID shall hold their previous values.
REQ-030 Responses shall return in issue order; there is no backpressure on responses, so requesters must accept them.
REQ-031 OUTSTANDING shall be +1 on issue, -1 on retire, and unchanged on a simultaneous issue and retire; it never exceeds MUL_LAT.
REQ-032 BUSY shall equal (OUTSTANDING != 0).
REQ-033 Asserting HOLD mid-stream shall not cancel in-flight operations; their responses still appear at the scheduled edges.

Reset
REQ-034 While RST is high, all of the following shall be 0: tags, LAST (so requester 0 has first priority), OUTSTANDING, BUSY, RSP_VALID, RSP_RESULT, RSP_EXCE and RSP_ID.
REQ-035 Reset asserted mid-operation shall discard all in-flight tags; no RSP_VALID shall appear for pre-reset issues, even if MUL_RESULT later changes.
REQ-036 After RST deasserts, the first grant may occur at the first CLK edge.

Verification
REQ-037 Single op: REQ_VALID=0001, OP1=0x4000000000000000 (2.0), OP2=0x4008000000000000 (3.0), multiplier model latency 6 -> RSP_VALID=0001 exactly 6 edges after the handshake, RSP_RESULT=0x4018000000000000, RSP_ID=0.
REQ-038 All four requesters valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; OUTSTANDING saturates at 6; responses arrive in the same id order, one per cycle.
REQ-039 REQ_VALID=1010 with LAST=1 -> grant 3, then 1; requester 0 is never granted.
REQ-040 HOLD=1 with 3 ops in flight -> REQ_READY=0; three responses follow; then BUSY=0 and OUTSTANDING=0.
REQ-041 RST pulsed 2 cycles after an issue -> no RSP_VALID ever for that op; all outputs are 0; the next grant goes to requester 0.
REQ-042 REQ_EXCE[2]=1 on requester 2's op -> RSP_EXCE=1 with RSP_VALID=0100; an adjacent op with REQ_EXCE=0 -> RSP_EXCE=0.
